// File: rtl/serial_mult_dot_ctrl_if.sv
// Operand-pair input stream and dot-product result stream of serial_mult_dot_ctrl.
// The slave side is the controller; the master side is the producer/consumer around it.
interface serial_mult_dot_ctrl_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4,
    parameter int ACC_WIDTH = 2*WIDTH+CNT_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/serial_mult_dot_ctrl.sv
// Sequencer around a fixed-latency serial multiplier: one start per operand pair,
// product captured MULT_LAT edges after start, accumulated into a dot product.
module serial_mult_dot_ctrl #(
    parameter int HALF_WIDTH = 4,
    parameter int WIDTH      = 2*HALF_WIDTH,
    parameter int MULT_LAT   = 10,
    parameter int CNT_WIDTH  = 4,
    parameter int ACC_WIDTH  = 2*WIDTH+CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_mult_dot_ctrl_if.slave  bus,
    output logic                   o_mult_start,
    output logic [WIDTH-1:0]       o_mult_a,
    output logic [WIDTH-1:0]       o_mult_b,
    input  logic [2*WIDTH-1:0]     i_mult_dout
);
    localparam int WCNT_W = $clog2(MULT_LAT+1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               r_state;
    logic                 r_last;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_ovf;
    logic [WCNT_W-1:0]    r_wait_cnt;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_mult_start;
    logic [WIDTH-1:0]     r_mult_a;
    logic [WIDTH-1:0]     r_mult_b;

    logic                 w_accept;
    logic                 w_capture;
    logic [ACC_WIDTH:0]   w_sum;
    logic [CNT_WIDTH-1:0] w_count_next;

    assign w_accept     = bus.in_valid & r_in_ready;
    assign w_capture    = (r_wait_cnt == WCNT_W'(MULT_LAT-1));
    // One extra bit on the adder exposes the accumulator carry-out.
    assign w_sum        = {1'b0, r_acc} + (ACC_WIDTH+1)'(i_mult_dout);
    assign w_count_next = r_count + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last       <= 1'b0;
            r_acc        <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_wait_cnt   <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_mult_start <= 1'b0;
            r_mult_a     <= '0;
            r_mult_b     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mult_a     <= bus.in_a;
                        r_mult_b     <= bus.in_b;
                        r_last       <= bus.in_last;
                        r_in_ready   <= 1'b0;
                        r_mult_start <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // This edge is where the multiplier samples start.
                    r_mult_start <= 1'b0;
                    r_wait_cnt   <= '0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                    if (w_capture) begin
                        r_acc   <= w_sum[ACC_WIDTH-1:0];
                        r_count <= w_count_next;
                        if (w_sum[ACC_WIDTH] || (&r_count))
                            r_ovf <= 1'b1;
                        if (r_last) begin
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_in_ready  <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_acc;
    assign bus.out_count = r_count;
    assign bus.out_ovf   = r_ovf;
    assign o_mult_start  = r_mult_start;
    assign o_mult_a      = r_mult_a;
    assign o_mult_b      = r_mult_b;
endmodule

// File: tb/tb_serial_mult_dot_ctrl.sv
// Scoreboard bench for serial_mult_dot_ctrl with a behavioural fixed-latency multiplier.
module tb_serial_mult_dot_ctrl;
    localparam int HALF_WIDTH = 4;
    localparam int WIDTH      = 2*HALF_WIDTH;
    localparam int MULT_LAT   = 10;
    localparam int CNT_WIDTH  = 4;
    localparam int ACC_WIDTH  = 2*WIDTH+CNT_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_mult_dot_ctrl_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

    logic               mult_start;
    logic [WIDTH-1:0]   mult_a;
    logic [WIDTH-1:0]   mult_b;
    logic [2*WIDTH-1:0] mult_dout;

    serial_mult_dot_ctrl #(
        .HALF_WIDTH(HALF_WIDTH), .WIDTH(WIDTH), .MULT_LAT(MULT_LAT),
        .CNT_WIDTH(CNT_WIDTH), .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .o_mult_start(mult_start),
        .o_mult_a(mult_a),
        .o_mult_b(mult_b),
        .i_mult_dout(mult_dout)
    );

    typedef struct {
        longint sum;
        int     count;
        bit     ovf;
    } exp_t;

    exp_t    exp_q[$];
    longint  start_q[$];
    int      errors = 0;
    int      checks = 0;
    longint  cyc = 0;
    longint  accept_cyc = 0;
    int      ready_mode = 0;
    int      va[$];
    int      vb[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Multiplier stand-in: garbage until one edge before the capture edge, then the product.
    initial begin
        logic [WIDTH-1:0] ma;
        logic [WIDTH-1:0] mb;
        mult_dout = '0;
        forever begin
            @(negedge clk);
            if (rst_n && mult_start) begin
                ma = mult_a;
                mb = mult_b;
                @(posedge clk);
                #1 mult_dout = 16'($urandom);
                @(negedge clk);
                check("start_pulse_width", {63'd0, mult_start}, 64'd0);
                repeat (MULT_LAT-1) @(posedge clk);
                #1 mult_dout = ma * mb;
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: latency, hold-under-backpressure and scoreboard comparison.
    initial begin
        bit                   prev_valid;
        bit                   prev_hold;
        logic [ACC_WIDTH-1:0] prev_sum;
        logic [CNT_WIDTH-1:0] prev_cnt;
        logic                 prev_ovf;
        exp_t                 e;
        prev_valid = 0;
        prev_hold  = 0;
        prev_sum   = '0;
        prev_cnt   = '0;
        prev_ovf   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0;
                prev_hold  = 0;
            end else begin
                if (mult_start) start_q.push_back(cyc);
                if (bus.in_valid && bus.in_ready) accept_cyc = cyc;
                if (bus.out_valid && !prev_valid)
                    check("result_latency", 64'(cyc - accept_cyc), 64'(MULT_LAT+2));
                if (prev_hold) begin
                    check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
                    check("hold_sum", 64'(bus.out_sum), 64'(prev_sum));
                    check("hold_count", 64'(bus.out_count), 64'(prev_cnt));
                    check("hold_ovf", {63'd0, bus.out_ovf}, {63'd0, prev_ovf});
                end
                if (bus.out_valid)
                    check("in_ready_while_done", {63'd0, bus.in_ready}, 64'd0);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got sum %0d expected no result", bus.out_sum);
                    end else begin
                        e = exp_q.pop_front();
                        $display("result sum=%0d count=%0d ovf=%0d (expected %0d/%0d/%0d)",
                                 bus.out_sum, bus.out_count, bus.out_ovf, e.sum, e.count, e.ovf);
                        check("out_sum", 64'(bus.out_sum), 64'(e.sum));
                        check("out_count", 64'(bus.out_count), 64'(e.count));
                        check("out_ovf", {63'd0, bus.out_ovf}, {63'd0, e.ovf});
                    end
                end
                prev_valid = bus.out_valid;
                prev_hold  = bus.out_valid && !bus.out_ready;
                prev_sum   = bus.out_sum;
                prev_cnt   = bus.out_count;
                prev_ovf   = bus.out_ovf;
            end
        end
    end

    task automatic send_pair(input int a, input int b, input bit last);
        int n;
        n = 0;
        bus.in_a     = 8'(a);
        bus.in_b     = 8'(b);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 2000);
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 2000 cycles");
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Reference: plain sum of products, wrapped to the accumulator and counter widths.
    task automatic send_vec(input bit gaps);
        exp_t   e;
        longint s;
        int     n;
        s = 0;
        n = va.size();
        foreach (va[i]) s += longint'(va[i]) * longint'(vb[i]);
        e.sum   = s % (longint'(1) << ACC_WIDTH);
        e.count = n % (1 << CNT_WIDTH);
        e.ovf   = (s >= (longint'(1) << ACC_WIDTH)) || (n >= (1 << CNT_WIDTH));
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            send_pair(va[i], vb[i], i == n-1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("result_arrived", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec1(input int a, input int b);
        va = {};
        vb = {};
        va.push_back(a);
        vb.push_back(b);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_mult_start", {63'd0, mult_start}, 64'd0);
        check("reset_mult_a", 64'(mult_a), 64'd0);
        check("reset_sum", 64'(bus.out_sum), 64'd0);
        check("reset_count", 64'(bus.out_count), 64'd0);
        @(posedge clk);
        #1;

        // Single pair
        set_vec1(200, 150);
        send_vec(0);
        drain();

        // Three-element vector, start pulses back to back
        start_q = {};
        va = {3, 5, 255};
        vb = {4, 6, 255};
        send_vec(0);
        drain();
        check("start_pulses", 64'(start_q.size()), 64'd3);
        if (start_q.size() == 3) begin
            check("start_spacing_1", 64'(start_q[1] - start_q[0]), 64'(MULT_LAT+2));
            check("start_spacing_2", 64'(start_q[2] - start_q[1]), 64'(MULT_LAT+2));
        end

        // Backpressure on the result, then confirm the accumulator was cleared
        ready_mode = 2;
        set_vec1(10, 20);
        send_vec(0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("bp_valid_held", {63'd0, bus.out_valid}, 64'd1);
        check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        ready_mode = 0;
        drain();
        set_vec1(7, 8);
        send_vec(0);
        drain();

        // Zero operands
        va = {0, 0};
        vb = {255, 0};
        send_vec(0);
        drain();

        // Count wrap and accumulator carry, then sticky flag cleared by the handoff
        va = {};
        vb = {};
        for (int i = 0; i < 17; i++) begin
            va.push_back(255);
            vb.push_back(255);
        end
        send_vec(0);
        drain();
        set_vec1(1, 1);
        send_vec(0);
        drain();

        // Asynchronous reset during the wait of the second element
        send_pair(4, 5, 0);
        send_pair(6, 7, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        check("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midreset_mult_start", {63'd0, mult_start}, 64'd0);
        check("midreset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        repeat (20) @(posedge clk);
        #1;
        set_vec1(2, 3);
        send_vec(0);
        drain();

        // Random vectors with random gaps and random result backpressure
        ready_mode = 1;
        for (int v = 0; v < 25; v++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(1, 5));
            va = {};
            vb = {};
            for (int i = 0; i < len; i++) begin
                va.push_back(int'($urandom_range(0, 255)));
                vb.push_back(int'($urandom_range(0, 255)));
            end
            send_vec(1);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_mult_dot_ctrl.md
Name: serial_mult_dot_ctrl

Overview:
Sequencing front/back-end for serial_multrom_mult_top, which has a start pulse, fixed latency and no done flag. Accepts operand pairs over a valid/ready stream and issues one multiplier start per pair. Captures dout after a fixed latency, accumulates the products into a dot-product and presents the sum on a valid/ready output when the pair tagged last completes. Drives the multiplier's start/mult1/mult2 ports and consumes its dout.

Parameters:
HALF_WIDTH, 4, half operand width; passed through to the paired multiplier.
WIDTH, 2*HALF_WIDTH, operand width.
MULT_LAT, 10, rising edges from the start-sampling edge to the edge where dout is captured; must be >= the multiplier's true latency.
CNT_WIDTH, 4, element counter width.
ACC_WIDTH, 2*WIDTH+CNT_WIDTH, accumulator width.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept a pair
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_last  in  1  pair is final element of the vector
mult_start  out  1  one-cycle start pulse to the multiplier
mult_a  out  WIDTH  to multiplier mult1
mult_b  out  WIDTH  to multiplier mult2
mult_dout  in  2*WIDTH  multiplier product (dout)
out_valid  out  1  dot-product result valid
out_ready  in  1  downstream accepts result
out_sum  out  ACC_WIDTH  accumulated sum
out_count  out  CNT_WIDTH  number of elements accumulated (mod 2^CNT_WIDTH)
out_ovf  out  1  sticky: accumulator carry-out or element-count wrap in this vector

Behaviour:
- Reset (async, rst_n=0): state IDLE; mult_start=0; mult_a=mult_b=0; acc=0; count=0; ovf=0; wait counter=0; out_valid=0.
- in_ready=1 after reset.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready: register in_a→mult_a, in_b→mult_b and in_last; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mult_start=1; in_ready=0.
  - The edge leaving ISSUE is edge E0, where the multiplier samples start.
  - Clear the wait counter; go to WAIT.
- WAIT:
  - mult_start=0; in_ready=0; mult_a/mult_b held stable.
  - Wait counter increments each edge.
  - At edge E0+MULT_LAT (counter==MULT_LAT-1): acc<=acc+mult_dout (zero-extended) and count<=count+1.
  - Set ovf if the add carries out of ACC_WIDTH or count wraps from 2^CNT_WIDTH-1 to 0.
  - Then go to DONE if the registered last=1, else IDLE.
- Accumulator and count wrap modulo their widths; ovf stays set until result handoff.
- DONE:
  - out_valid=1; out_sum=acc; out_count=count; out_ovf=ovf; all held stable while out_ready=0.
  - in_ready=0.
  - On an edge with out_valid&out_ready: clear acc, count and ovf; go to IDLE.
- Outside DONE: out_valid=0; out_sum/out_count/out_ovf show live registers (don't-care).
- Throughput: 1 accept cycle + 1 ISSUE + MULT_LAT WAIT cycles per element, i.e. MULT_LAT+2 cycles per pair.
- A new pair is accepted the cycle after WAIT or DONE exits; no overlap with an in-flight multiply.
- in_valid while in_ready=0 is ignored; the source must hold it.
- out_ready while not DONE is ignored.
- Reset mid-operation: immediate return to IDLE with all registers cleared; the partial vector is discarded; mult_start drops asynchronously.
- mult_start is registered (state-decoded from a flop), glitch-free.

Test Plan:
1. Single pair in_a=200, in_b=150, in_last=1 → mult_start high exactly 1 cycle; out_valid rises MULT_LAT+2 edges after accept; out_sum=30000, out_count=1, out_ovf=0.
2. Vector (3,4),(5,6),(255,255, last) → out_sum=65067, out_count=3, out_ovf=0; exactly 3 start pulses, spaced 12 cycles apart.
3. Backpressure: result pending with out_ready=0 for 5 cycles → out_valid, out_sum and out_count stable; in_ready=0. After out_ready=1, the next pair (7,8,last) → out_sum=56, confirming acc was cleared.
4. Zero operands: (0,255),(0,0,last) → out_sum=0, out_count=2.
5. Overflow/wrap: 17 pairs of (255,255), last on the 17th → out_count=1, out_sum=56849, out_ovf=1. Next vector (1,1,last) → out_ovf=0, out_sum=1.
6. Reset during WAIT of the second element: rst_n low for 1 ns → out_valid=0, mult_start=0, in_ready=1 after release. A subsequent (2,3,last) → out_sum=6, out_count=1.
